// File: rtl/cnt4_updown_mod.sv
// cnt4_updown_mod: 4-bit up/down counter with load, cascade carry, modulus and sticky overflow, built from library cells
module dff_cell (
    input  logic clk,
    input  logic c,
    input  logic d,
    output logic q
);
    // Rising-edge flop with asynchronous clear pin
    always_ff @(posedge clk or posedge c)
        if (c) q <= 1'b0;
        else   q <= d;
endmodule

module not_cell (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module and2_cell (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module or2_cell (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module xor2_cell (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module nor4_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y
);
    assign y = ~(a | b | c | d);
endmodule

module mux2_cell (
    input  logic s,
    input  logic a0,
    input  logic a1,
    output logic y
);
    logic ns, t0, t1;
    not_cell  u_n  (.a(s),  .y(ns));
    and2_cell u_a0 (.a(a0), .b(ns), .y(t0));
    and2_cell u_a1 (.a(a1), .b(s),  .y(t1));
    or2_cell  u_o  (.a(t0), .b(t1), .y(y));
endmodule

module cnt4_updown_mod #(
    parameter int MODULUS = 16
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       EN,
    input  logic       CI,
    input  logic       UP,
    input  logic       LD,
    input  logic [3:0] D,
    input  logic       CLR_OVF,
    output logic [3:0] Q,
    output logic       CO,
    output logic       OVF
);
    localparam logic [3:0] TERM = 4'(MODULUS - 1);
    localparam logic [3:0] MODV = 4'(MODULUS);

    if (MODULUS < 2 || MODULUS > 16) begin : g_bad_mod
        $error("cnt4_updown_mod: MODULUS must be 2..16");
    end

    logic [3:0] q, inc, dec, up_n, dn_n, cnt_v, hold_v, nxt, d_q;
    logic [3:0] ic, bc;
    logic [2:0] nq;
    logic [4:0] ge_t;
    logic z, oor, sel_t, n_ge, wrap_sel, cnt_en, n_ld, cnt, wrap;
    logic ovf, n_clr, keep, ovf_n, ovf_d;

    assign ge_t[0] = 1'b1;
    assign ic[0]   = 1'b1;
    assign bc[0]   = 1'b1;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        // q >= TERM, resolved LSB-first: a 1 in TERM needs q[i]=1, a 0 in TERM is beaten by q[i]=1
        if (TERM[i]) begin : g_ge1
            and2_cell u_ge (.a(q[i]), .b(ge_t[i]), .y(ge_t[i+1]));
        end else begin : g_ge0
            or2_cell  u_ge (.a(q[i]), .b(ge_t[i]), .y(ge_t[i+1]));
        end
        xor2_cell u_inc (.a(q[i]), .b(ic[i]), .y(inc[i]));
        xor2_cell u_dec (.a(q[i]), .b(bc[i]), .y(dec[i]));
        if (i < 3) begin : g_chain
            not_cell  u_nq  (.a(q[i]),  .y(nq[i]));
            and2_cell u_ic  (.a(q[i]),  .b(ic[i]), .y(ic[i+1]));
            and2_cell u_bc  (.a(nq[i]), .b(bc[i]), .y(bc[i+1]));
        end
        and2_cell u_up  (.a(inc[i]),    .b(n_ge),      .y(up_n[i]));
        mux2_cell u_dn  (.s(sel_t),     .a0(dec[i]),   .a1(TERM[i]),  .y(dn_n[i]));
        mux2_cell u_dir (.s(UP),        .a0(dn_n[i]),  .a1(up_n[i]),  .y(cnt_v[i]));
        mux2_cell u_hld (.s(cnt),       .a0(q[i]),     .a1(cnt_v[i]), .y(hold_v[i]));
        mux2_cell u_ld  (.s(LD),        .a0(hold_v[i]),.a1(D[i]),     .y(nxt[i]));
        and2_cell u_rst (.a(RSTN),      .b(nxt[i]),    .y(d_q[i]));
        dff_cell  u_ff  (.clk(CLK), .c(1'b0), .d(d_q[i]), .q(q[i]));
    end

    // Out-of-range detect (q >= MODULUS) only exists when some 4-bit values lie beyond the modulus
    if (MODULUS == 16) begin : g_full
        assign oor = 1'b0;
    end else begin : g_part
        logic [4:0] ge_m;
        assign ge_m[0] = 1'b1;
        for (genvar i = 0; i < 4; i++) begin : g_m
            if (MODV[i]) begin : g_m1
                and2_cell u_gm (.a(q[i]), .b(ge_m[i]), .y(ge_m[i+1]));
            end else begin : g_m0
                or2_cell  u_gm (.a(q[i]), .b(ge_m[i]), .y(ge_m[i+1]));
            end
        end
        assign oor = ge_m[4];
    end

    nor4_cell u_z    (.a(q[0]), .b(q[1]), .c(q[2]), .d(q[3]), .y(z));
    not_cell  u_nge  (.a(ge_t[4]), .y(n_ge));
    or2_cell  u_selt (.a(z), .b(oor), .y(sel_t));
    mux2_cell u_wsel (.s(UP), .a0(z), .a1(ge_t[4]), .y(wrap_sel));
    and2_cell u_cen  (.a(EN), .b(CI), .y(cnt_en));
    and2_cell u_co   (.a(cnt_en), .b(wrap_sel), .y(CO));
    not_cell  u_nld  (.a(LD), .y(n_ld));
    and2_cell u_cnt  (.a(cnt_en), .b(n_ld), .y(cnt));
    and2_cell u_wrap (.a(cnt), .b(wrap_sel), .y(wrap));

    // Sticky overflow: a wrap sets it and beats a simultaneous clear
    not_cell  u_nclr (.a(CLR_OVF), .y(n_clr));
    and2_cell u_keep (.a(ovf), .b(n_clr), .y(keep));
    or2_cell  u_ovfn (.a(wrap), .b(keep), .y(ovf_n));
    and2_cell u_ovfr (.a(RSTN), .b(ovf_n), .y(ovf_d));
    dff_cell  u_ovf  (.clk(CLK), .c(1'b0), .d(ovf_d), .q(ovf));

    assign Q   = q;
    assign OVF = ovf;
endmodule

// File: tb/tb_cnt4_updown_mod.sv
// tb_cnt4_updown_mod: directed vectors for a modulus-10 counter plus a modulus-16 cascade pair
module tb_cnt4_updown_mod;
    logic clk;
    logic a_rstn, a_en, a_ci, a_up, a_ld, a_clr, a_co, a_ovf;
    logic [3:0] a_d, a_q;
    logic c_rstn, c_en, c_ci, c_up, c_ld, c_clr;
    logic [3:0] c_d, lo_q, hi_q;
    logic lo_co, hi_co, lo_ovf, hi_ovf;
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] cnt;

    typedef struct {
        logic rstn, en, ci, up, ld;
        logic [3:0] d;
        logic clr, cc, co;
        logic [3:0] q;
        logic ovf;
    } vec_t;
    vec_t tv[$];

    cnt4_updown_mod #(.MODULUS(10)) u_a (
        .CLK(clk), .RSTN(a_rstn), .EN(a_en), .CI(a_ci), .UP(a_up), .LD(a_ld),
        .D(a_d), .CLR_OVF(a_clr), .Q(a_q), .CO(a_co), .OVF(a_ovf)
    );
    cnt4_updown_mod #(.MODULUS(16)) u_lo (
        .CLK(clk), .RSTN(c_rstn), .EN(c_en), .CI(c_ci), .UP(c_up), .LD(c_ld),
        .D(c_d), .CLR_OVF(c_clr), .Q(lo_q), .CO(lo_co), .OVF(lo_ovf)
    );
    cnt4_updown_mod #(.MODULUS(16)) u_hi (
        .CLK(clk), .RSTN(c_rstn), .EN(c_en), .CI(lo_co), .UP(c_up), .LD(1'b0),
        .D(4'd0), .CLR_OVF(c_clr), .Q(hi_q), .CO(hi_co), .OVF(hi_ovf)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic rstn, en, ci, up, ld, input logic [3:0] d,
                                input logic clr, cc, co, input logic [3:0] q, input logic ovf);
        vec_t v;
        v.rstn = rstn; v.en = en; v.ci = ci; v.up = up; v.ld = ld; v.d = d;
        v.clr = clr; v.cc = cc; v.co = co; v.q = q; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        {a_rstn, a_en, a_ci, a_up, a_ld, a_clr, a_d} = '0;
        {c_rstn, c_en, c_ci, c_up, c_ld, c_clr, c_d} = '0;
        //              rstn en ci up ld  d  clr cc co  q  ovf
        tv.push_back(mk(0, 1, 1, 1, 1, 9,  0, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 1, 1, 1, 9,  0, 1, 0, 0, 0));
        for (int k = 1; k <= 9; k++)
            tv.push_back(mk(1, 1, 1, 1, 0, 0, 0, 1, 0, 4'(k), 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 0,  0, 1, 1, 0, 1));
        tv.push_back(mk(1, 1, 1, 1, 0, 0,  0, 1, 0, 1, 1));
        tv.push_back(mk(1, 0, 1, 1, 0, 0,  0, 1, 0, 1, 1));
        tv.push_back(mk(1, 1, 1, 0, 1, 1,  1, 1, 0, 1, 0));
        tv.push_back(mk(1, 1, 1, 0, 0, 0,  0, 1, 0, 0, 0));
        tv.push_back(mk(1, 1, 1, 0, 0, 0,  0, 1, 1, 9, 1));
        tv.push_back(mk(1, 0, 1, 0, 0, 0,  1, 1, 0, 9, 0));
        tv.push_back(mk(1, 1, 1, 0, 1, 0,  0, 1, 0, 0, 0));
        tv.push_back(mk(1, 1, 1, 0, 0, 0,  1, 1, 1, 9, 1));
        tv.push_back(mk(1, 1, 0, 0, 0, 0,  0, 1, 0, 9, 1));
        tv.push_back(mk(1, 1, 1, 1, 1, 14, 1, 1, 1, 14, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 0,  0, 1, 1, 0, 1));
        tv.push_back(mk(1, 1, 1, 0, 1, 14, 1, 1, 1, 14, 0));
        tv.push_back(mk(1, 1, 1, 0, 0, 0,  0, 1, 0, 9, 0));
        tv.push_back(mk(1, 1, 1, 0, 0, 0,  0, 1, 0, 8, 0));
        tv.push_back(mk(0, 1, 1, 1, 1, 5,  0, 1, 0, 0, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 0,  0, 1, 0, 1, 0));

        foreach (tv[k]) begin
            @(negedge clk);
            a_rstn = tv[k].rstn; a_en = tv[k].en; a_ci = tv[k].ci; a_up = tv[k].up;
            a_ld = tv[k].ld; a_d = tv[k].d; a_clr = tv[k].clr;
            #1;
            if (tv[k].cc) chk($sformatf("v%0d_co", k), 8'(a_co), 8'(tv[k].co));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_q", k), 8'(a_q), 8'(tv[k].q));
            chk($sformatf("v%0d_ovf", k), 8'(a_ovf), 8'(tv[k].ovf));
        end

        @(negedge clk);
        c_rstn = 0; c_en = 1; c_ci = 1; c_up = 1; c_ld = 1; c_d = 9; c_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("c_rst_lo", 8'(lo_q), 8'd0);
        chk("c_rst_hi", 8'(hi_q), 8'd0);
        chk("c_rst_ovf", {6'd0, hi_ovf, lo_ovf}, 8'd0);
        @(negedge clk);
        c_rstn = 1; c_d = 5;
        @(posedge clk);
        #1 chk("ld5", 8'(lo_q), 8'd5);
        @(negedge clk);
        c_d = 12;
        @(posedge clk);
        #1;
        chk("ld_prio", 8'(lo_q), 8'd12);
        chk("ld_prio_hi", 8'(hi_q), 8'd0);
        @(negedge clk);
        c_rstn = 0; c_d = 7;
        @(posedge clk);
        #1 chk("rst_over_ld", 8'(lo_q), 8'd0);

        @(negedge clk);
        c_rstn = 1; c_ld = 0; cnt = 0;
        for (int k = 0; k < 256; k++) begin
            #1 chk($sformatf("casc%0d_co", k), 8'(lo_co), 8'(cnt[3:0] == 4'hF));
            @(posedge clk);
            #1;
            cnt++;
            chk($sformatf("casc%0d_q", k), {hi_q, lo_q}, cnt);
            chk($sformatf("casc%0d_hovf", k), 8'(hi_ovf), 8'(k == 255));
            @(negedge clk);
        end
        repeat (15) @(posedge clk);
        #1 chk("casc_0f", {hi_q, lo_q}, 8'h0F);
        @(negedge clk);
        c_ci = 0;
        #1 chk("freeze_co", 8'(lo_co), 8'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("freeze_q", {hi_q, lo_q}, 8'h0F);
        chk("freeze_hovf", 8'(hi_ovf), 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
